// File: rtl/pipe_skid_stage_pkg.sv
// Shared definitions for the pipeline stage register.
//   id_ex_t      : packed ID->EX bundle; its member order fixes the field offsets
//                  (aluop in the MSBs down to delay_addr in the LSBs).
//   ID_EX_W      : width of the packed bundle, used as the default payload width.
//   ID_EX_NOP    : bubble value inserted when the stage holds nothing.
//   stage_state_e: 2-bit occupancy encoding shared by both stage variants.
package pipe_skid_stage_pkg;

  localparam logic [7:0] ALUOP_NOP = 8'h00;
  localparam logic [2:0] RES_NOP   = 3'b000;

  typedef struct packed {
    logic [7:0]  aluop;
    logic [2:0]  alusel;
    logic [31:0] reg1;
    logic [31:0] reg2;
    logic [4:0]  wd;
    logic        wreg;
    logic [15:0] imm;
    logic        in_delay_slot;
    logic        next_in_delay_slot;
    logic [31:0] delay_addr;
  } id_ex_t;

  localparam int ID_EX_W = $bits(id_ex_t);

  // A bubble is a no-op ALU operation that writes no result.
  function automatic id_ex_t id_ex_nop();
    id_ex_t b;
    b        = '0;
    b.aluop  = ALUOP_NOP;
    b.alusel = RES_NOP;
    b.wreg   = 1'b0;
    return b;
  endfunction

  localparam id_ex_t ID_EX_NOP = id_ex_nop();

  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_FULL  = 2'd1,
    ST_SKID  = 2'd2
  } stage_state_e;

endpackage

// File: rtl/pipe_sat_counter.sv
// Saturating up-counter.
// Ports:
//   clk  : rising-edge clock
//   rst  : asynchronous active-low reset, clears the count
//   inc  : count one on this edge
//   cnt  : current count, sticks at all-ones
module pipe_sat_counter #(
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             inc,
  output logic [CNT_W-1:0] cnt
);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt <= '0;
    end else if (inc && (cnt != {CNT_W{1'b1}})) begin
      cnt <= cnt + CNT_W'(1);
    end
  end

endmodule

// File: rtl/pipe_skid_stage.sv
// Pipeline-stage register with valid/ready handshake, optional 2-entry skid
// buffer, synchronous flush and a saturating stall counter.
//
//   state    | meaning
//   ---------+--------------------------------------------------------------
//   ST_EMPTY | nothing held, out_data is the bubble, in_ready=1
//   ST_FULL  | main register holds the output payload, in_ready=1
//   ST_SKID  | main and skid both hold payloads, in_ready=0 (SKID=1 only)
//
// Ports:
//   clk       : rising-edge clock
//   rst       : asynchronous active-low reset
//   flush     : drop everything held, present a bubble next cycle
//   in_valid  : upstream payload valid
//   in_ready  : stage accepts this cycle
//   in_data   : upstream payload
//   out_valid : payload held for downstream
//   out_ready : downstream accepts this cycle
//   out_data  : held payload, NOP_VAL when out_valid=0
//   stall_cnt : edges with out_valid=1 and out_ready=0, saturating
module pipe_skid_stage
  import pipe_skid_stage_pkg::*;
#(
  parameter int                DATA_W  = ID_EX_W,
  parameter logic [DATA_W-1:0] NOP_VAL = DATA_W'(ID_EX_NOP),
  parameter int                SKID    = 1,
  parameter int                CNT_W   = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic [CNT_W-1:0]  stall_cnt
);

  stage_state_e      state_q, state_d;
  logic [DATA_W-1:0] main_q, main_d;
  logic              in_fire, out_fire;

  // Every path into ST_EMPTY reloads main with the bubble, so the output
  // bus can be driven straight from the register.
  assign out_valid = (state_q != ST_EMPTY);
  assign out_data  = main_q;
  assign in_fire   = in_valid & in_ready;
  assign out_fire  = out_valid & out_ready;

  generate
    if (SKID != 0) begin : g_skid
      logic [DATA_W-1:0] skid_q, skid_d;

      // Registered ready: depends only on occupancy, never on out_ready.
      assign in_ready = (state_q != ST_SKID);

      always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
          state_q <= ST_EMPTY;
          main_q  <= NOP_VAL;
          skid_q  <= NOP_VAL;
        end else begin
          state_q <= state_d;
          main_q  <= main_d;
          skid_q  <= skid_d;
        end
      end

      always_comb begin
        state_d = state_q;
        main_d  = main_q;
        skid_d  = skid_q;
        case (state_q)
          ST_EMPTY: begin
            if (in_fire) begin
              state_d = ST_FULL;
              main_d  = in_data;
            end
          end
          ST_FULL: begin
            if (in_fire && out_fire) begin
              main_d = in_data;
            end else if (in_fire) begin
              state_d = ST_SKID;
              skid_d  = in_data;
            end else if (out_fire) begin
              state_d = ST_EMPTY;
              main_d  = NOP_VAL;
            end
          end
          ST_SKID: begin
            if (out_fire) begin
              state_d = ST_FULL;
              main_d  = skid_q;
              skid_d  = NOP_VAL;
            end
          end
          default: begin
            state_d = ST_EMPTY;
            main_d  = NOP_VAL;
            skid_d  = NOP_VAL;
          end
        endcase
        // Flush wins over any transfer in the same cycle, including an
        // accepted input, which is simply discarded.
        if (flush) begin
          state_d = ST_EMPTY;
          main_d  = NOP_VAL;
          skid_d  = NOP_VAL;
        end
      end
    end else begin : g_single
      // Single register: ready passes through combinationally so the
      // stage can refill in the same cycle it drains.
      assign in_ready = ~out_valid | out_ready;

      always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
          state_q <= ST_EMPTY;
          main_q  <= NOP_VAL;
        end else begin
          state_q <= state_d;
          main_q  <= main_d;
        end
      end

      always_comb begin
        state_d = state_q;
        main_d  = main_q;
        if (in_fire) begin
          state_d = ST_FULL;
          main_d  = in_data;
        end else if (out_fire) begin
          state_d = ST_EMPTY;
          main_d  = NOP_VAL;
        end else if (state_q == ST_SKID) begin
          state_d = ST_EMPTY;
          main_d  = NOP_VAL;
        end
        if (flush) begin
          state_d = ST_EMPTY;
          main_d  = NOP_VAL;
        end
      end
    end
  endgenerate

  pipe_sat_counter #(
    .CNT_W (CNT_W)
  ) u_stall_cnt (
    .clk (clk),
    .rst (rst),
    .inc (out_valid & ~out_ready),
    .cnt (stall_cnt)
  );

endmodule

// File: tb/tb_pipe_skid_stage.sv
module tb_pipe_skid_stage;

  localparam logic [130:0] NOP_A = '0;
  localparam logic [15:0]  NOP_B = 16'hDEAD;
  localparam logic [7:0]   NOP_C = 8'h5A;

  logic         clk = 1'b0;
  logic         rst;
  logic         flush;
  logic         in_valid;
  logic         out_ready;
  logic [130:0] in_data;

  logic         in_ready_a, out_valid_a;
  logic [130:0] out_data_a;
  logic [31:0]  stall_a;
  logic         in_ready_b, out_valid_b;
  logic [15:0]  out_data_b;
  logic [31:0]  stall_b;
  logic         in_ready_c, out_valid_c;
  logic [7:0]   out_data_c;
  logic [3:0]   stall_c;

  int n_checks = 0;
  int n_errors = 0;

  // Reference model: each stage is a FIFO with a capacity (2 with skid,
  // 1 without) plus a plain stall counter.
  logic [130:0] qa[$];
  logic [15:0]  qb[$];
  logic [7:0]   qc[$];
  int unsigned  sa, sb, sc;

  always #5 clk = ~clk;

  pipe_skid_stage dut_a (
    .clk(clk), .rst(rst), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready_a), .in_data(in_data),
    .out_valid(out_valid_a), .out_ready(out_ready), .out_data(out_data_a),
    .stall_cnt(stall_a)
  );

  pipe_skid_stage #(.DATA_W(16), .NOP_VAL(16'hDEAD), .SKID(0), .CNT_W(32)) dut_b (
    .clk(clk), .rst(rst), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready_b), .in_data(in_data[15:0]),
    .out_valid(out_valid_b), .out_ready(out_ready), .out_data(out_data_b),
    .stall_cnt(stall_b)
  );

  pipe_skid_stage #(.DATA_W(8), .NOP_VAL(8'h5A), .SKID(1), .CNT_W(4)) dut_c (
    .clk(clk), .rst(rst), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready_c), .in_data(in_data[7:0]),
    .out_valid(out_valid_c), .out_ready(out_ready), .out_data(out_data_c),
    .stall_cnt(stall_c)
  );

  task automatic check_eq(input string tag, input logic [130:0] got, input logic [130:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic check_all();
    logic [130:0] ea;
    logic [15:0]  eb;
    logic [7:0]   ec;
    ea = NOP_A; eb = NOP_B; ec = NOP_C;
    if (qa.size() != 0) ea = qa[0];
    if (qb.size() != 0) eb = qb[0];
    if (qc.size() != 0) ec = qc[0];
    check_eq("a_in_ready",  in_ready_a,  qa.size() < 2);
    check_eq("a_out_valid", out_valid_a, qa.size() != 0);
    check_eq("a_out_data",  out_data_a,  ea);
    check_eq("a_stall_cnt", stall_a,     sa);
    check_eq("b_in_ready",  in_ready_b,  (qb.size() == 0) || out_ready);
    check_eq("b_out_valid", out_valid_b, qb.size() != 0);
    check_eq("b_out_data",  out_data_b,  eb);
    check_eq("b_stall_cnt", stall_b,     sb);
    check_eq("c_in_ready",  in_ready_c,  qc.size() < 2);
    check_eq("c_out_valid", out_valid_c, qc.size() != 0);
    check_eq("c_out_data",  out_data_c,  ec);
    check_eq("c_stall_cnt", stall_c,     sc);
  endtask

  task automatic model_clear();
    qa.delete(); qb.delete(); qc.delete();
    sa = 0; sb = 0; sc = 0;
  endtask

  // One clock cycle: drive inputs, check at the falling edge, advance model.
  task automatic cycle(input logic v, input logic [130:0] d, input logic ordy, input logic fl);
    bit push, pop;
    in_valid = v; in_data = d; out_ready = ordy; flush = fl;
    @(negedge clk);
    check_all();
    if (qa.size() != 0 && !ordy) sa++;
    if (qb.size() != 0 && !ordy) sb++;
    if (qc.size() != 0 && !ordy && sc < 15) sc++;
    if (fl) begin
      qa.delete(); qb.delete(); qc.delete();
    end else begin
      push = v && (qa.size() < 2);
      pop  = (qa.size() != 0) && ordy;
      if (pop)  void'(qa.pop_front());
      if (push) qa.push_back(d);
      push = v && ((qb.size() == 0) || ordy);
      pop  = (qb.size() != 0) && ordy;
      if (pop)  void'(qb.pop_front());
      if (push) qb.push_back(d[15:0]);
      push = v && (qc.size() < 2);
      pop  = (qc.size() != 0) && ordy;
      if (pop)  void'(qc.pop_front());
      if (push) qc.push_back(d[7:0]);
    end
    @(posedge clk);
    #1;
  endtask

  function automatic logic [130:0] rand_data();
    logic [159:0] t;
    t = {$urandom, $urandom, $urandom, $urandom, $urandom};
    return t[130:0];
  endfunction

  initial begin
    rst = 1'b0; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0; in_data = '0;
    model_clear();
    @(posedge clk);
    #1;
    check_eq("rst_a_out_valid", out_valid_a, 1'b0);
    check_eq("rst_a_out_data",  out_data_a,  NOP_A);
    check_eq("rst_b_out_data",  out_data_b,  NOP_B);
    check_eq("rst_c_stall_cnt", stall_c,     4'd0);
    rst = 1'b1;

    // Streaming at full rate.
    cycle(1, 131'h1, 1, 0);
    cycle(1, 131'h2, 1, 0);
    cycle(1, 131'h3, 1, 0);
    cycle(0, '0, 1, 0);
    cycle(0, '0, 1, 0);

    // Backpressure into the skid entry, then drain in order.
    cycle(1, 131'hA, 0, 0);
    cycle(1, 131'hB, 0, 0);
    cycle(0, '0, 0, 0);
    cycle(0, '0, 1, 0);
    cycle(0, '0, 1, 0);
    cycle(0, '0, 1, 0);

    // Flush while skid is full, with a new payload offered the same cycle.
    cycle(1, 131'hA, 0, 0);
    cycle(1, 131'hB, 0, 0);
    cycle(1, 131'hC, 0, 1);
    cycle(0, '0, 1, 0);
    cycle(0, '0, 1, 0);

    // Single-register variant: full + stalled, then push while draining.
    cycle(1, 131'h11, 0, 0);
    cycle(1, 131'h22, 0, 0);
    cycle(1, 131'h33, 1, 0);
    cycle(0, '0, 1, 0);
    cycle(0, '0, 1, 0);

    // Counter saturation on the 4-bit instance.
    cycle(1, 131'h44, 0, 0);
    for (int i = 0; i < 20; i++) cycle(0, '0, 0, 0);
    check_eq("c_stall_saturated", stall_c, 4'hF);
    cycle(0, '0, 1, 1);
    cycle(0, '0, 1, 0);

    // Asynchronous reset between clock edges with the skid entry occupied.
    cycle(1, 131'hA, 0, 0);
    cycle(1, 131'hB, 0, 0);
    cycle(0, '0, 0, 0);
    in_valid = 1'b0; out_ready = 1'b0; flush = 1'b0;
    #2;
    rst = 1'b0;
    #1;
    check_eq("arst_a_out_valid", out_valid_a, 1'b0);
    check_eq("arst_a_out_data",  out_data_a,  NOP_A);
    check_eq("arst_a_in_ready",  in_ready_a,  1'b1);
    check_eq("arst_a_stall_cnt", stall_a,     32'd0);
    check_eq("arst_c_out_data",  out_data_c,  NOP_C);
    check_eq("arst_b_out_valid", out_valid_b, 1'b0);
    model_clear();
    @(posedge clk);
    #1;
    rst = 1'b1;

    // Randomized traffic: a phase with heavy backpressure, then a mixed one.
    for (int i = 0; i < 300; i++)
      cycle($urandom_range(0, 3) != 0, rand_data(), $urandom_range(0, 3) == 0,
            $urandom_range(0, 40) == 0);
    for (int i = 0; i < 500; i++)
      cycle($urandom_range(0, 2) != 0, rand_data(), $urandom_range(0, 2) != 0,
            $urandom_range(0, 25) == 0);
    cycle(0, '0, 1, 0);
    cycle(0, '0, 1, 0);
    cycle(0, '0, 1, 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
